// File: rtl/pulse_train_sequencer.sv
// pulse_train_sequencer
// Runs a burst of optical trigger pulses around an external delay generator.
// A start in IDLE latches the burst configuration. Each pulse then goes
// through the same loop: arm the generator, wait for its expired flag, hold
// PL_out high for the programmed width, and (if more pulses remain) drop
// DL_launch for the programmed gap. Every output is a flop whose next value
// is computed alongside the next state, so outputs change exactly on the
// edge that enters the corresponding state.

module pulse_train_sequencer #(
    parameter int DW = 35,
    parameter int NW = 8,
    parameter int TW = 16
) (
    input  logic          clk_Seq,
    input  logic          rst_Seq_n,
    input  logic          start,
    input  logic          abort,
    input  logic [NW-1:0] n_pulses,
    input  logic [DW-1:0] delay_cfg,
    input  logic [TW-1:0] width_cfg,
    input  logic [TW-1:0] gap_cfg,
    input  logic          launch_PL,
    output logic          DL_launch,
    output logic [DW-1:0] delay,
    output logic          PL_out,
    output logic          busy,
    output logic          done,
    output logic [NW-1:0] pulse_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_FIRE = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Timer reload value for a programmed span: a zero span still lasts one
    // cycle, so the reload is max(cfg,1)-1 and the phase ends when the timer
    // reads zero.
    function automatic logic [TW-1:0] span_m1(input logic [TW-1:0] cfg);
        logic [TW-1:0] r;
        if (cfg == {TW{1'b0}}) begin
            r = {TW{1'b0}};
        end else begin
            r = cfg - {{(TW-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    state_t        state_q,     state_d;
    logic [TW-1:0] tmr_q,       tmr_d;
    logic [NW-1:0] n_q,         n_d;
    logic [TW-1:0] width_q,     width_d;
    logic [TW-1:0] gap_q,       gap_d;
    logic [DW-1:0] delay_q,     delay_d;
    logic [NW-1:0] pulse_cnt_q, pulse_cnt_d;
    logic          dl_launch_q, dl_launch_d;
    logic          pl_out_q,    pl_out_d;
    logic          busy_q,      busy_d;
    logic          done_q,      done_d;

    logic [NW:0]   cnt_inc_s;
    logic          last_pulse_s;
    logic [NW-1:0] cnt_sat_s;
    logic          tmr_zero_s;
    logic [TW-1:0] tmr_dec_s;

    // Pulse-count arithmetic: one extra bit so the "this was the last pulse"
    // compare cannot wrap, and the increment saturates at the burst length.
    always_comb begin
        cnt_inc_s    = {1'b0, pulse_cnt_q} + {{NW{1'b0}}, 1'b1};
        last_pulse_s = (cnt_inc_s == {1'b0, n_q});
        if (pulse_cnt_q < n_q) begin
            cnt_sat_s = cnt_inc_s[NW-1:0];
        end else begin
            cnt_sat_s = pulse_cnt_q;
        end
        tmr_zero_s = (tmr_q == {TW{1'b0}});
        tmr_dec_s  = tmr_q - {{(TW-1){1'b0}}, 1'b1};
    end

    // Next-state and next-output logic for the burst sequencer.
    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        n_d         = n_q;
        width_d     = width_q;
        gap_d       = gap_q;
        delay_d     = delay_q;
        pulse_cnt_d = pulse_cnt_q;
        dl_launch_d = dl_launch_q;
        pl_out_d    = pl_out_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                dl_launch_d = 1'b0;
                pl_out_d    = 1'b0;
                if (start && !abort) begin
                    n_d         = n_pulses;
                    delay_d     = delay_cfg;
                    width_d     = width_cfg;
                    gap_d       = gap_cfg;
                    pulse_cnt_d = {NW{1'b0}};
                    busy_d      = 1'b1;
                    if (n_pulses == {NW{1'b0}}) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = ST_ARM;
                        dl_launch_d = 1'b1;
                    end
                end else begin
                    busy_d = 1'b0;
                end
            end

            ST_ARM: begin
                if (abort) begin
                    state_d     = ST_IDLE;
                    dl_launch_d = 1'b0;
                    pl_out_d    = 1'b0;
                    busy_d      = 1'b0;
                end else if (launch_PL) begin
                    state_d     = ST_FIRE;
                    dl_launch_d = 1'b1;
                    pl_out_d    = 1'b1;
                    tmr_d       = span_m1(width_q);
                end else begin
                    dl_launch_d = 1'b1;
                end
            end

            ST_FIRE: begin
                if (abort) begin
                    state_d     = ST_IDLE;
                    dl_launch_d = 1'b0;
                    pl_out_d    = 1'b0;
                    busy_d      = 1'b0;
                end else if (tmr_zero_s) begin
                    pulse_cnt_d = cnt_sat_s;
                    pl_out_d    = 1'b0;
                    dl_launch_d = 1'b0;
                    if (last_pulse_s) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_GAP;
                        tmr_d   = span_m1(gap_q);
                    end
                end else begin
                    tmr_d = tmr_dec_s;
                end
            end

            ST_GAP: begin
                if (abort) begin
                    state_d     = ST_IDLE;
                    dl_launch_d = 1'b0;
                    pl_out_d    = 1'b0;
                    busy_d      = 1'b0;
                end else if (tmr_zero_s) begin
                    state_d     = ST_ARM;
                    dl_launch_d = 1'b1;
                end else begin
                    tmr_d = tmr_dec_s;
                end
            end

            ST_DONE: begin
                state_d     = ST_IDLE;
                dl_launch_d = 1'b0;
                pl_out_d    = 1'b0;
                busy_d      = 1'b0;
            end

            default: begin
                state_d     = ST_IDLE;
                dl_launch_d = 1'b0;
                pl_out_d    = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State, latched configuration and output registers; reset clears every
    // output without waiting for a clock edge.
    always_ff @(posedge clk_Seq or negedge rst_Seq_n) begin
        if (!rst_Seq_n) begin
            state_q     <= ST_IDLE;
            tmr_q       <= {TW{1'b0}};
            n_q         <= {NW{1'b0}};
            width_q     <= {TW{1'b0}};
            gap_q       <= {TW{1'b0}};
            delay_q     <= {DW{1'b0}};
            pulse_cnt_q <= {NW{1'b0}};
            dl_launch_q <= 1'b0;
            pl_out_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            n_q         <= n_d;
            width_q     <= width_d;
            gap_q       <= gap_d;
            delay_q     <= delay_d;
            pulse_cnt_q <= pulse_cnt_d;
            dl_launch_q <= dl_launch_d;
            pl_out_q    <= pl_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign DL_launch = dl_launch_q;
    assign delay     = delay_q;
    assign PL_out    = pl_out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pulse_cnt = pulse_cnt_q;

endmodule

// File: tb/tb_pulse_train_sequencer.sv
// Testbench for pulse_train_sequencer. A behavioural delay generator closes
// the loop on DL_launch/delay/launch_PL. For each burst the stimulus side
// computes the whole expected output timeline from the burst arithmetic
// (pulse period (D+2)+W+G, last pulse without gap, done, abort truncation)
// and queues it tagged with absolute cycle numbers; an independent monitor
// compares the DUT against the queue on every falling edge.

module tb_pulse_train_sequencer;

    localparam int DW = 35;
    localparam int NW = 8;
    localparam int TW = 16;

    logic          clk_Seq = 1'b0;
    logic          rst_Seq_n;
    logic          start;
    logic          abort;
    logic [NW-1:0] n_pulses;
    logic [DW-1:0] delay_cfg;
    logic [TW-1:0] width_cfg;
    logic [TW-1:0] gap_cfg;
    logic          launch_PL;
    logic          DL_launch;
    logic [DW-1:0] delay;
    logic          PL_out;
    logic          busy;
    logic          done;
    logic [NW-1:0] pulse_cnt;

    pulse_train_sequencer #(.DW(DW), .NW(NW), .TW(TW)) dut (
        .clk_Seq   (clk_Seq),
        .rst_Seq_n (rst_Seq_n),
        .start     (start),
        .abort     (abort),
        .n_pulses  (n_pulses),
        .delay_cfg (delay_cfg),
        .width_cfg (width_cfg),
        .gap_cfg   (gap_cfg),
        .launch_PL (launch_PL),
        .DL_launch (DL_launch),
        .delay     (delay),
        .PL_out    (PL_out),
        .busy      (busy),
        .done      (done),
        .pulse_cnt (pulse_cnt)
    );

    always #5 clk_Seq = ~clk_Seq;

    int cyc = 0;
    always @(posedge clk_Seq) cyc <= cyc + 1;

    // Delay generator model: counts while launched, raises launch_PL after
    // 'delay' further cycles, clears as soon as DL_launch is seen low.
    logic [DW-1:0] dg_cnt;
    always @(posedge clk_Seq or negedge rst_Seq_n) begin
        if (!rst_Seq_n) begin
            dg_cnt    <= '0;
            launch_PL <= 1'b0;
        end else if (!DL_launch) begin
            dg_cnt    <= '0;
            launch_PL <= 1'b0;
        end else if (dg_cnt == delay) begin
            launch_PL <= 1'b1;
        end else begin
            dg_cnt <= dg_cnt + 1'b1;
        end
    end

    typedef struct {
        int            cyc;
        logic          dl;
        logic          pl;
        logic          bsy;
        logic          dn;
        logic [NW-1:0] cnt;
        logic [DW-1:0] dly;
    } exp_t;

    exp_t q[$];
    int   errs   = 0;
    int   checks = 0;
    exp_t mon_e;

    logic [NW-1:0] last_cnt;
    logic [DW-1:0] last_dly;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, req);
        end
    endtask

    // Monitor: compare DUT outputs against the queued expectation for this cycle.
    always @(negedge clk_Seq) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
            mon_e = q.pop_front();
            chk("schedule", 64'(mon_e.cyc), 64'(cyc));
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            mon_e = q.pop_front();
            chk("DL_launch", 64'(DL_launch), 64'(mon_e.dl));
            chk("PL_out",    64'(PL_out),    64'(mon_e.pl));
            chk("busy",      64'(busy),      64'(mon_e.bsy));
            chk("done",      64'(done),      64'(mon_e.dn));
            chk("pulse_cnt", 64'(pulse_cnt), 64'(mon_e.cnt));
            chk("delay",     64'(delay),     64'(mon_e.dly));
        end
    end

    function automatic void push_rec(input int c, input logic dl, input logic pl, input logic bsy,
                                     input logic dn, input logic [NW-1:0] cnt, input logic [DW-1:0] dly);
        exp_t r;
        r.cyc = c; r.dl = dl; r.pl = pl; r.bsy = bsy; r.dn = dn; r.cnt = cnt; r.dly = dly;
        q.push_back(r);
    endfunction

    task automatic step();
        @(posedge clk_Seq);
        #2;
    endtask

    // Expected pulse count t cycles after the start edge of an unaborted burst.
    function automatic int cnt_at(input int t, input int n, input int d, input int wd, input int p, input int td);
        int r;
        if (t >= td) r = n;
        else if ((t % p) >= d + 2 + wd) r = t / p + 1;
        else r = t / p;
        return r;
    endfunction

    // Queue the full expected timeline of a burst that starts on the next edge.
    // abort_t > 0 means abort is sampled on edge e(abort_t).
    task automatic push_burst(input int n, input int d, input int w, input int g, input int abort_t,
                              output int len, output int end_t);
        int wd, gd, p, td, c0, o, hold;
        wd = (w == 0) ? 1 : w;
        gd = (g == 0) ? 1 : g;
        p  = d + 2 + wd + gd;
        td = (n == 0) ? 0 : (n - 1) * p + d + 2 + wd;
        c0 = cyc + 1;
        end_t = (abort_t > 0) ? abort_t : td + 1;
        for (int t = 0; t < end_t; t++) begin
            o = t % p;
            if (t == td)
                push_rec(c0 + t, 1'b0, 1'b0, 1'b1, 1'b1, NW'(n), DW'(d));
            else
                push_rec(c0 + t, o < d + 2 + wd, (o >= d + 2) && (o < d + 2 + wd), 1'b1, 1'b0,
                         NW'(cnt_at(t, n, d, wd, p, td)), DW'(d));
        end
        hold = (abort_t > 0) ? cnt_at(abort_t - 1, n, d, wd, p, td) : n;
        for (int t = end_t; t < end_t + 2; t++)
            push_rec(c0 + t, 1'b0, 1'b0, 1'b0, 1'b0, NW'(hold), DW'(d));
        len      = end_t + 2;
        last_cnt = NW'(hold);
        last_dly = DW'(d);
    endtask

    // Issue one burst; with junk set, scribble config and re-start while busy.
    task automatic run_burst(input int n, input int d, input int w, input int g,
                             input int abort_t, input bit junk);
        int len, end_t;
        push_burst(n, d, w, g, abort_t, len, end_t);
        n_pulses  = NW'(n);
        delay_cfg = DW'(d);
        width_cfg = TW'(w);
        gap_cfg   = TW'(g);
        start     = 1'b1;
        abort     = 1'b0;
        step();
        start = 1'b0;
        for (int t = 1; t < len; t++) begin
            abort = (t == abort_t);
            if (junk) begin
                n_pulses  = NW'($urandom);
                delay_cfg = DW'({$urandom, $urandom});
                width_cfg = TW'($urandom);
                gap_cfg   = TW'($urandom);
                start     = (t <= end_t) ? 1'($urandom_range(0, 1)) : 1'b0;
            end else begin
                start = 1'b0;
            end
            step();
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    int rn, rd, rw, rg, ra, rtd;

    initial begin
        rst_Seq_n = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        n_pulses  = '0;
        delay_cfg = '0;
        width_cfg = '0;
        gap_cfg   = '0;
        last_cnt  = '0;
        last_dly  = '0;
        step();
        push_rec(cyc, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        step();
        rst_Seq_n = 1'b1;
        step();

        run_burst(1, 3, 2, 1, 0, 1'b0);
        run_burst(2, 3, 2, 1, 0, 1'b0);
        run_burst(0, 3, 1, 1, 0, 1'b0);
        run_burst(2, 0, 0, 0, 0, 1'b0);
        run_burst(4, 3, 2, 1, 10, 1'b0);

        // start and abort together in IDLE: nothing moves
        n_pulses  = NW'(3);
        delay_cfg = DW'(7);
        start     = 1'b1;
        abort     = 1'b1;
        for (int k = 1; k <= 3; k++)
            push_rec(cyc + k, 1'b0, 1'b0, 1'b0, 1'b0, last_cnt, last_dly);
        step();
        start = 1'b0;
        abort = 1'b0;
        step();
        step();

        run_burst(3, 2, 3, 2, 0, 1'b1);

        // Reset in the middle of a FIRE phase
        n_pulses  = NW'(3);
        delay_cfg = DW'(2);
        width_cfg = TW'(4);
        gap_cfg   = TW'(1);
        start     = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 5; k++) step();
        q.delete();
        rst_Seq_n = 1'b0;
        push_rec(cyc, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        push_rec(cyc + 1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        step();
        rst_Seq_n = 1'b1;
        last_cnt  = '0;
        last_dly  = '0;
        step();

        run_burst(1, 3, 2, 1, 0, 1'b0);

        for (int i = 0; i < 14; i++) begin
            rn = $urandom_range(0, 4);
            rd = $urandom_range(0, 6);
            rw = $urandom_range(0, 3);
            rg = $urandom_range(0, 3);
            ra = 0;
            if (rn > 0 && $urandom_range(0, 3) == 0) begin
                rtd = (rn - 1) * (rd + 2 + ((rw == 0) ? 1 : rw) + ((rg == 0) ? 1 : rg))
                      + rd + 2 + ((rw == 0) ? 1 : rw);
                ra = $urandom_range(1, rtd);
            end
            run_burst(rn, rd, rw, rg, ra, 1'($urandom_range(0, 1)));
        end

        step();
        step();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/pulse_train_sequencer.md
# pulse_train_sequencer

Sequences a burst of optical synchronizing pulses around the delay generator. On a start command it latches a burst configuration, then repeatedly arms the delay generator, waits for its delay-expired flag, emits a trigger pulse of programmed width, and re-arms after a programmed gap until the pulse count is reached. It sits between the control/configuration logic and the delay generator, and owns that generator's launch and delay inputs exclusively.

## Interface
- DW, 35, delay value width; matches the delay generator's delay input.
- NW, 8, pulse-count width.
- TW, 16, width and gap counter width.

- clk_Seq  in  1  system clock; all logic on the rising edge.
- rst_Seq_n  in  1  asynchronous, active-low reset.
- start  in  1  burst request; sampled only in IDLE.
- abort  in  1  terminates any burst; takes effect at the next edge.
- n_pulses  in  NW  number of pulses in the burst; latched on start.
- delay_cfg  in  DW  delay value; latched on start.
- width_cfg  in  TW  PL_out high time in cycles; latched on start; 0 is treated as 1.
- gap_cfg  in  TW  DL_launch low time between pulses in cycles; latched on start; 0 is treated as 1.
- launch_PL  in  1  delay-expired flag from the delay generator.
- DL_launch  out  1  launch signal to the delay generator.
- delay  out  DW  latched delay_cfg, driven to the delay generator.
- PL_out  out  1  optical trigger pulse.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a burst completes normally.
- pulse_cnt  out  NW  number of pulses completed in the current or last burst.

## Operation
- All outputs are registered. Reset value of every output is 0, and the state is IDLE. Reset clears all outputs immediately, including during a burst.
- IDLE state:
  - start=1 and abort=0 latches the configuration and clears pulse_cnt.
  - If n_pulses=0, the next state is DONE. Otherwise the next state is ARM.
- ARM state:
  - DL_launch=1.
  - launch_PL is sampled every edge. launch_PL=1 moves the state to FIRE.
- FIRE state:
  - DL_launch=1 and PL_out=1 for exactly max(width_cfg,1) cycles.
  - On exit, pulse_cnt increments.
  - If pulse_cnt+1 equals n_pulses, the next state is DONE. Otherwise the next state is GAP.
- GAP state:
  - DL_launch=0 and PL_out=0 for exactly max(gap_cfg,1) cycles, then the next state is ARM.
  - The minimum gap of one cycle guarantees that the delay generator clears its counter and launch_PL before the next arm.
- DONE state:
  - DL_launch=0 and done=1 for one cycle, then the next state is IDLE.
- Abort:
  - In ARM, FIRE or GAP, abort=1 forces IDLE at the next edge with DL_launch, PL_out and busy at 0.
  - done is not asserted. pulse_cnt holds its value.
- Ignored and competing inputs:
  - start while busy=1 is ignored.
  - In IDLE, start and abort in the same cycle: abort wins, and the block stays in IDLE.
- Configuration: inputs may change during a burst without effect. The delay output holds the latched value until the next accepted start.
- pulse_cnt saturates at n_pulses and never wraps.
- launch_PL has no timeout; abort is the only way out of a hung ARM state.

## Timing
- The start edge is e0. DL_launch rises after e0, and busy rises after e0.
- With the delay generator connected and delay D:
  - launch_PL rises after e(D+1).
  - The sequencer enters FIRE at e(D+2), so PL_out rises D+2 cycles after DL_launch.
- Pulse period within a burst is (D+2) + W + G cycles, where W=max(width_cfg,1) and G=max(gap_cfg,1).
- After the last FIRE there is no GAP:
  - done is high in the cycle immediately after PL_out falls.
  - busy falls one cycle after done.
- Abort latency is one edge. Reset latency is combinational (asynchronous).

## Test plan
- Single pulse, n=1, D=3, W=2, G=1:
  - DL_launch high after e0, PL_out high after e5 through e7.
  - done high after e7 for one cycle; busy low after e8; pulse_cnt=1.
- Burst, n=2, D=3, W=2, G=1:
  - PL_out rises after e5 and after e13.
  - DL_launch is low exactly for the cycle after e7.
  - done after e15; pulse_cnt=2.
- Zero-count and zero-width:
  - n=0: done after e0 for one cycle, DL_launch never rises.
  - width_cfg=0, gap_cfg=0 with n=2, D=0: PL_out pulses one cycle each, with a period of 4 cycles.
- Abort:
  - Abort during the second ARM of an n=4 burst: all outputs low at the next edge, no done, pulse_cnt=1.
  - start and abort together in IDLE: block stays in IDLE.
- Reset mid-FIRE: assert rst_Seq_n=0 between edges → PL_out, DL_launch and busy drop to 0 without waiting for a clock edge. The next start behaves normally.
- start while busy and config changes mid-burst: pulse timing and delay output are unchanged from the latched values.
